// File: rtl/lsu_mem_requester.sv
// ---------------------------------------------------------------------------
// lsu_mem_requester
//
// Turns single load/store requests from the LSU into transactions on a simple
// memory-controller handshake. At most one request is in flight.
//
//   * Loads: one read, then the selected byte/half/word is extracted,
//     sign- or zero-extended and returned with its tag.
//   * Word stores: a single write.
//   * Byte/half stores: read-modify-write. The read word has its low bits
//     replaced by the store data, then the merged word is written back.
//   * flush_in drops the result of an in-flight load, but the bus transfer
//     still runs to completion. Stores are committed, so flush has no effect
//     on them.
//   * rdy_in low freezes the block. res_valid_out is masked while frozen.
//
// Ports
//   clk_in, rst_in (async, active-low), rdy_in (global ready / hold)
//   req_*      upstream request with valid/ready handshake
//   res_*      one-cycle result pulse with load data (0 for stores) and tag
//   flush_in   discard uncompleted loads
//   *_memctrl  memory-controller request/response
// ---------------------------------------------------------------------------
module lsu_mem_requester #(
    parameter int TAG_WIDTH = 4
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 rdy_in,
    input  logic                 req_valid_in,
    output logic                 req_ready_out,
    input  logic                 req_is_store_in,
    input  logic [2:0]           req_funct3_in,
    input  logic [31:0]          req_addr_in,
    input  logic [31:0]          req_data_in,
    input  logic [TAG_WIDTH-1:0] req_tag_in,
    output logic                 res_valid_out,
    output logic [31:0]          res_data_out,
    output logic [TAG_WIDTH-1:0] res_tag_out,
    input  logic                 flush_in,
    output logic                 enable_to_memctrl,
    output logic                 rw_flag_to_memctrl,
    output logic [31:0]          address_to_memctrl,
    output logic [31:0]          data_to_memctrl,
    input  logic                 available_from_memctrl,
    input  logic                 end_from_memctrl,
    input  logic [31:0]          data_from_memctrl
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_READ  = 2'b01,
        ST_WRITE = 2'b10,
        ST_GAP   = 2'b11
    } state_t;

    state_t                 state_r;
    logic                   granted_r;   // controller has taken the request (available seen low)
    logic                   flushed_r;   // load was flushed while in flight
    logic                   wr_wait_r;   // idle cycle between RMW read and write
    logic                   is_store_r;
    logic [2:0]             funct3_r;
    logic [TAG_WIDTH-1:0]   tag_r;
    logic                   res_valid_r;
    logic                   accept_s;
    logic                   done_s;

    // Extract and extend the addressed part of a read word for a load.
    function automatic logic [31:0] load_extract(input logic [2:0] f3, input logic [31:0] w);
        logic [31:0] r;
        case (f3)
            3'b000:  r = {{24{w[7]}}, w[7:0]};
            3'b001:  r = {{16{w[15]}}, w[15:0]};
            3'b100:  r = {24'h000000, w[7:0]};
            3'b101:  r = {16'h0000, w[15:0]};
            default: r = w;
        endcase
        return r;
    endfunction

    // Merge byte/half store data into the low bits of the read word.
    function automatic logic [31:0] store_merge(input logic [2:0] f3, input logic [31:0] rd,
                                                input logic [31:0] st);
        logic [31:0] r;
        case (f3[1:0])
            2'b00:   r = {rd[31:8], st[7:0]};
            2'b01:   r = {rd[31:16], st[15:0]};
            default: r = st;
        endcase
        return r;
    endfunction

    // Ready is masked by the reset input so nothing is accepted while reset is held.
    assign req_ready_out = rst_in & rdy_in & ~flush_in & (state_r == ST_IDLE);
    assign accept_s      = req_valid_in & req_ready_out;
    // end_from_memctrl only counts once the controller has shown it took the request.
    assign done_s        = granted_r & end_from_memctrl;
    // A pending pulse stays registered during a hold and is shown once rdy returns.
    assign res_valid_out = res_valid_r & rdy_in;

    // Request FSM with all memory-side and result outputs registered.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_r            <= ST_IDLE;
            granted_r          <= 1'b0;
            flushed_r          <= 1'b0;
            wr_wait_r          <= 1'b0;
            is_store_r         <= 1'b0;
            funct3_r           <= 3'b000;
            tag_r              <= '0;
            enable_to_memctrl  <= 1'b0;
            rw_flag_to_memctrl <= 1'b1;
            address_to_memctrl <= 32'h0000_0000;
            data_to_memctrl    <= 32'h0000_0000;
            res_valid_r        <= 1'b0;
            res_data_out       <= 32'h0000_0000;
            res_tag_out        <= '0;
        end else if (rdy_in) begin
            res_valid_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        is_store_r         <= req_is_store_in;
                        funct3_r           <= req_funct3_in;
                        tag_r              <= req_tag_in;
                        address_to_memctrl <= req_addr_in;
                        data_to_memctrl    <= req_data_in;
                        granted_r          <= 1'b0;
                        flushed_r          <= 1'b0;
                        wr_wait_r          <= 1'b0;
                        enable_to_memctrl  <= 1'b1;
                        // Only full-word stores can skip the read half of RMW.
                        if (req_is_store_in && (req_funct3_in[1:0] == 2'b10)) begin
                            state_r            <= ST_WRITE;
                            rw_flag_to_memctrl <= 1'b0;
                        end else begin
                            state_r            <= ST_READ;
                            rw_flag_to_memctrl <= 1'b1;
                        end
                    end
                end
                ST_READ: begin
                    if (done_s) begin
                        granted_r         <= 1'b0;
                        enable_to_memctrl <= 1'b0;
                        if (is_store_r) begin
                            data_to_memctrl    <= store_merge(funct3_r, data_from_memctrl, data_to_memctrl);
                            rw_flag_to_memctrl <= 1'b0;
                            wr_wait_r          <= 1'b1;
                            state_r            <= ST_WRITE;
                        end else begin
                            // A flush on the completion edge itself also drops the result.
                            if (!flushed_r && !flush_in) begin
                                res_valid_r  <= 1'b1;
                                res_data_out <= load_extract(funct3_r, data_from_memctrl);
                                res_tag_out  <= tag_r;
                            end
                            state_r <= ST_GAP;
                        end
                    end else begin
                        if (!available_from_memctrl) begin
                            granted_r <= 1'b1;
                        end
                        if (flush_in && !is_store_r) begin
                            flushed_r <= 1'b1;
                        end
                    end
                end
                ST_WRITE: begin
                    if (wr_wait_r) begin
                        // Controller sees enable low for a cycle between read and write.
                        wr_wait_r         <= 1'b0;
                        enable_to_memctrl <= 1'b1;
                    end else if (done_s) begin
                        granted_r          <= 1'b0;
                        enable_to_memctrl  <= 1'b0;
                        rw_flag_to_memctrl <= 1'b1;
                        res_valid_r        <= 1'b1;
                        res_data_out       <= 32'h0000_0000;
                        res_tag_out        <= tag_r;
                        state_r            <= ST_GAP;
                    end else if (!available_from_memctrl) begin
                        granted_r <= 1'b1;
                    end
                end
                ST_GAP: begin
                    if (available_from_memctrl) begin
                        state_r <= ST_IDLE;
                    end
                end
                default: begin
                    state_r           <= ST_IDLE;
                    enable_to_memctrl <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_mem_requester.sv
module tb_lsu_mem_requester;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        rdy_in;
    logic        req_valid_in;
    logic        req_ready_out;
    logic        req_is_store_in;
    logic [2:0]  req_funct3_in;
    logic [31:0] req_addr_in;
    logic [31:0] req_data_in;
    logic [3:0]  req_tag_in;
    logic        res_valid_out;
    logic [31:0] res_data_out;
    logic [3:0]  res_tag_out;
    logic        flush_in;
    logic        enable_to_memctrl;
    logic        rw_flag_to_memctrl;
    logic [31:0] address_to_memctrl;
    logic [31:0] data_to_memctrl;
    logic        available_from_memctrl;
    logic        end_from_memctrl;
    logic [31:0] data_from_memctrl;

    lsu_mem_requester #(.TAG_WIDTH(4)) dut (
        .clk_in                 (clk_in),
        .rst_in                 (rst_in),
        .rdy_in                 (rdy_in),
        .req_valid_in           (req_valid_in),
        .req_ready_out          (req_ready_out),
        .req_is_store_in        (req_is_store_in),
        .req_funct3_in          (req_funct3_in),
        .req_addr_in            (req_addr_in),
        .req_data_in            (req_data_in),
        .req_tag_in             (req_tag_in),
        .res_valid_out          (res_valid_out),
        .res_data_out           (res_data_out),
        .res_tag_out            (res_tag_out),
        .flush_in               (flush_in),
        .enable_to_memctrl      (enable_to_memctrl),
        .rw_flag_to_memctrl     (rw_flag_to_memctrl),
        .address_to_memctrl     (address_to_memctrl),
        .data_to_memctrl        (data_to_memctrl),
        .available_from_memctrl (available_from_memctrl),
        .end_from_memctrl       (end_from_memctrl),
        .data_from_memctrl      (data_from_memctrl)
    );

    always #5 clk_in = ~clk_in;

    int checks = 0;
    int errors = 0;
    int n_res  = 0;
    int n_rd   = 0;
    int n_wr   = 0;

    logic [31:0] exp_data[$];
    logic [3:0]  exp_tag[$];
    logic [31:0] exp_wa[$];
    logic [31:0] exp_wd[$];

    logic [7:0]  mem [0:1023];
    int          mc_lat        = 1;
    int          mc_grab_delay = 0;
    logic        mc_stuck_end  = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] rdw(input logic [31:0] a);
        logic [9:0] i;
        i = a[9:0];
        return {mem[i + 10'd3], mem[i + 10'd2], mem[i + 10'd1], mem[i]};
    endfunction

    task automatic push_res(input logic [31:0] d, input logic [3:0] t);
        exp_data.push_back(d);
        exp_tag.push_back(t);
    endtask

    // Result monitor: pops the scoreboard whenever the DUT presents a result.
    always @(negedge clk_in) begin
        if (rst_in === 1'b1 && res_valid_out === 1'b1) begin
            n_res++;
            if (exp_data.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_result actual=%h/%h required=none", res_data_out, res_tag_out);
            end else begin
                chk("res_data", res_data_out, exp_data.pop_front());
                chk("res_tag", {28'd0, res_tag_out}, {28'd0, exp_tag.pop_front()});
            end
        end
    end

    // Memory-controller model; also checks every write against the write scoreboard.
    initial begin : memctrl
        int          phase;
        int          cnt;
        int          gcnt;
        logic [31:0] a;
        logic [9:0]  i;
        phase = 0; cnt = 0; gcnt = 0;
        available_from_memctrl = 1'b1;
        end_from_memctrl       = 1'b0;
        data_from_memctrl      = 32'hBAD0_BAD0;
        forever begin
            @(posedge clk_in); #1;
            case (phase)
                0: begin
                    available_from_memctrl = 1'b1;
                    end_from_memctrl       = mc_stuck_end;
                    data_from_memctrl      = 32'hBAD0_BAD0;
                    if (enable_to_memctrl === 1'b1) begin
                        if (gcnt < mc_grab_delay) begin
                            gcnt++;
                        end else begin
                            gcnt = 0; phase = 1; cnt = mc_lat;
                            available_from_memctrl = 1'b0;
                            end_from_memctrl       = 1'b0;
                        end
                    end else begin
                        gcnt = 0;
                    end
                end
                1: begin
                    if (enable_to_memctrl !== 1'b1) begin
                        phase = 0;
                        available_from_memctrl = 1'b1;
                    end else begin
                        cnt--;
                        if (cnt <= 0) begin
                            a = address_to_memctrl;
                            if (rw_flag_to_memctrl === 1'b1) begin
                                data_from_memctrl = rdw(a);
                                n_rd++;
                            end else begin
                                i = a[9:0];
                                {mem[i + 10'd3], mem[i + 10'd2], mem[i + 10'd1], mem[i]} = data_to_memctrl;
                                n_wr++;
                                if (exp_wa.size() == 0) begin
                                    checks++;
                                    errors++;
                                    $display("FAIL unexpected_write actual=%h:%h required=none", a, data_to_memctrl);
                                end else begin
                                    chk("wr_addr", a, exp_wa.pop_front());
                                    chk("wr_data", data_to_memctrl, exp_wd.pop_front());
                                end
                            end
                            end_from_memctrl = 1'b1;
                            phase = 2;
                        end
                    end
                end
                default: begin
                    if (enable_to_memctrl !== 1'b1) begin
                        end_from_memctrl       = 1'b0;
                        available_from_memctrl = 1'b1;
                        phase = 0;
                    end
                end
            endcase
        end
    end

    task automatic issue(input logic st, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] tag);
        int n;
        n = 0;
        req_valid_in = 1'b1; req_is_store_in = st; req_funct3_in = f3;
        req_addr_in = a; req_data_in = d; req_tag_in = tag;
        while (req_ready_out !== 1'b1 && n < 100) begin
            @(posedge clk_in); #1; n++;
        end
        if (n >= 100) begin
            checks++; errors++;
            $display("FAIL accept_timeout actual=not_ready required=ready");
        end
        @(posedge clk_in); #1;
        req_valid_in = 1'b0;
        chk("accept_enable", {31'd0, enable_to_memctrl}, 32'd1);
        chk("accept_rw", {31'd0, rw_flag_to_memctrl}, (st && f3[1:0] == 2'b10) ? 32'd0 : 32'd1);
        chk("accept_addr", address_to_memctrl, a);
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (req_ready_out !== 1'b1 && n < 200) begin
            @(posedge clk_in); #1; n++;
        end
        checks++;
        if (n >= 200) begin
            errors++;
            $display("FAIL %s idle_timeout actual=busy required=idle", name);
        end
    endtask

    task automatic step;
        @(posedge clk_in); #1;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin : main
        int r0;
        int w0;
        int q0;
        int n;
        for (int k = 0; k < 1024; k++) mem[k] = 8'h00;
        {mem[10'h103], mem[10'h102], mem[10'h101], mem[10'h100]} = 32'h5634_1280;
        {mem[10'h113], mem[10'h112], mem[10'h111], mem[10'h110]} = 32'hC3A5_F000;
        {mem[10'h203], mem[10'h202], mem[10'h201], mem[10'h200]} = 32'h4433_2211;
        {mem[10'h207], mem[10'h206], mem[10'h205], mem[10'h204]} = 32'h8877_6655;
        {mem[10'h20B], mem[10'h20A], mem[10'h209], mem[10'h208]} = 32'h0403_0201;
        {mem[10'h20F], mem[10'h20E], mem[10'h20D], mem[10'h20C]} = 32'h0D0C_0B0A;

        rst_in = 1'b0; rdy_in = 1'b1; flush_in = 1'b0;
        req_valid_in = 1'b0; req_is_store_in = 1'b0; req_funct3_in = 3'b000;
        req_addr_in = 32'h0; req_data_in = 32'h0; req_tag_in = 4'h0;
        repeat (2) step();
        chk("rst_enable", {31'd0, enable_to_memctrl}, 32'd0);
        chk("rst_rw", {31'd0, rw_flag_to_memctrl}, 32'd1);
        chk("rst_ready", {31'd0, req_ready_out}, 32'd0);
        chk("rst_res_valid", {31'd0, res_valid_out}, 32'd0);
        rst_in = 1'b1;
        step();
        chk("idle_ready", {31'd0, req_ready_out}, 32'd1);

        // Loads: byte / byte-unsigned / word with latency check / half variants.
        push_res(32'hFFFF_FF80, 4'd3); issue(1'b0, 3'b000, 32'h100, 32'h0, 4'd3); wait_idle("lb");
        push_res(32'h0000_0080, 4'd4); issue(1'b0, 3'b100, 32'h100, 32'h0, 4'd4); wait_idle("lbu");
        push_res(32'h5634_1280, 4'd5); issue(1'b0, 3'b010, 32'h100, 32'h0, 4'd5);
        step(); chk("lw_lat_early", {31'd0, res_valid_out}, 32'd0);
        step(); chk("lw_lat_pulse", {31'd0, res_valid_out}, 32'd1);
        wait_idle("lw");
        push_res(32'hFFFF_F000, 4'd6); issue(1'b0, 3'b001, 32'h110, 32'h0, 4'd6); wait_idle("lh");
        push_res(32'h0000_F000, 4'd7); issue(1'b0, 3'b101, 32'h110, 32'h0, 4'd7); wait_idle("lhu");

        // Half store read-modify-write.
        r0 = n_rd; w0 = n_wr; q0 = n_res;
        exp_wa.push_back(32'h200); exp_wd.push_back(32'h4433_BEEF); push_res(32'h0, 4'd8);
        issue(1'b1, 3'b001, 32'h200, 32'hAAAA_BEEF, 4'd8); wait_idle("sh");
        chk("sh_reads", n_rd - r0, 32'd1);
        chk("sh_writes", n_wr - w0, 32'd1);
        chk("sh_pulses", n_res - q0, 32'd1);
        chk("sh_mem", rdw(32'h200), 32'h4433_BEEF);

        // Byte store read-modify-write.
        exp_wa.push_back(32'h204); exp_wd.push_back(32'h8877_667A); push_res(32'h0, 4'd9);
        issue(1'b1, 3'b000, 32'h204, 32'h1234_567A, 4'd9); wait_idle("sb");

        // Word store: no read, enable low right after completion.
        r0 = n_rd; w0 = n_wr;
        exp_wa.push_back(32'h300); exp_wd.push_back(32'hDEAD_BEEF); push_res(32'h0, 4'd10);
        issue(1'b1, 3'b010, 32'h300, 32'hDEAD_BEEF, 4'd10);
        n = 0;
        while (res_valid_out !== 1'b1 && n < 50) begin step(); n++; end
        chk("sw_done_seen", (n < 50) ? 32'd1 : 32'd0, 32'd1);
        chk("sw_gap_enable", {31'd0, enable_to_memctrl}, 32'd0);
        chk("sw_gap_ready", {31'd0, req_ready_out}, 32'd0);
        wait_idle("sw");
        chk("sw_reads", n_rd - r0, 32'd0);
        chk("sw_writes", n_wr - w0, 32'd1);

        // Flush mid-READ of a load: transfer completes, result dropped.
        mc_lat = 4; q0 = n_res; r0 = n_rd;
        issue(1'b0, 3'b010, 32'h100, 32'h0, 4'd11);
        step(); flush_in = 1'b1;
        step(); flush_in = 1'b0;
        chk("flush_enable_held", {31'd0, enable_to_memctrl}, 32'd1);
        wait_idle("flush_lw");
        chk("flush_no_result", n_res - q0, 32'd0);
        chk("flush_read_done", n_rd - r0, 32'd1);
        mc_lat = 1;
        push_res(32'hC3A5_F000, 4'd12); issue(1'b0, 3'b010, 32'h110, 32'h0, 4'd12); wait_idle("after_flush");

        // Flush on the completion edge of a load.
        q0 = n_res;
        issue(1'b0, 3'b010, 32'h100, 32'h0, 4'd13);
        step(); flush_in = 1'b1;
        step(); flush_in = 1'b0;
        chk("flush_edge_valid", {31'd0, res_valid_out}, 32'd0);
        wait_idle("flush_edge");
        chk("flush_edge_no_result", n_res - q0, 32'd0);

        // Flush during a byte store's read: still written back and reported.
        mc_lat = 4;
        exp_wa.push_back(32'h208); exp_wd.push_back(32'h0403_02AB); push_res(32'h0, 4'd14);
        issue(1'b1, 3'b000, 32'h208, 32'h0000_00AB, 4'd14);
        step(); flush_in = 1'b1;
        step(); flush_in = 1'b0;
        wait_idle("flush_sb");

        // end held high before the controller takes the request.
        mc_lat = 1; mc_grab_delay = 3; mc_stuck_end = 1'b1;
        push_res(32'hC3A5_F000, 4'd15);
        issue(1'b0, 3'b010, 32'h110, 32'h0, 4'd15);
        step(); step();
        chk("stuck_end_enable", {31'd0, enable_to_memctrl}, 32'd1);
        chk("stuck_end_valid", {31'd0, res_valid_out}, 32'd0);
        wait_idle("stuck_end");
        mc_grab_delay = 0; mc_stuck_end = 1'b0;

        // Hold mid-READ for 5 cycles, then reset mid-WRITE.
        mc_lat = 2; q0 = n_res; w0 = n_wr;
        issue(1'b1, 3'b001, 32'h20C, 32'h0000_CAFE, 4'd1);
        step(); rdy_in = 1'b0;
        for (int c = 0; c < 5; c++) begin
            step();
            chk("hold_enable", {31'd0, enable_to_memctrl}, 32'd1);
            chk("hold_rw", {31'd0, rw_flag_to_memctrl}, 32'd1);
            chk("hold_addr", address_to_memctrl, 32'h20C);
            chk("hold_valid", {31'd0, res_valid_out}, 32'd0);
        end
        rdy_in = 1'b1; mc_lat = 6;
        n = 0;
        while (!(enable_to_memctrl === 1'b1 && rw_flag_to_memctrl === 1'b0) && n < 50) begin step(); n++; end
        chk("rmw_write_seen", (n < 50) ? 32'd1 : 32'd0, 32'd1);
        step();
        rst_in = 1'b0; #1;
        chk("arst_enable", {31'd0, enable_to_memctrl}, 32'd0);
        chk("arst_rw", {31'd0, rw_flag_to_memctrl}, 32'd1);
        chk("arst_addr", address_to_memctrl, 32'h0);
        chk("arst_data", data_to_memctrl, 32'h0);
        chk("arst_res_data", res_data_out, 32'h0);
        chk("arst_res_tag", {28'd0, res_tag_out}, 32'd0);
        chk("arst_ready", {31'd0, req_ready_out}, 32'd0);
        repeat (2) step();
        rst_in = 1'b1;
        repeat (5) step();
        chk("arst_no_write", n_wr - w0, 32'd0);
        chk("arst_no_result", n_res - q0, 32'd0);

        // Recovery after reset.
        mc_lat = 1;
        push_res(32'h4433_BEEF, 4'd2); issue(1'b0, 3'b010, 32'h200, 32'h0, 4'd2); wait_idle("recover");
        repeat (3) step();

        chk("res_queue_empty", exp_data.size(), 32'd0);
        chk("wr_queue_empty", exp_wa.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
